// File: rtl/i2c_slave_controller.sv
// i2c_slave_controller: 7-bit addressed I2C slave with a byte-wide receive
// handshake (rx_data/rx_valid/rx_ready) and transmit handshake
// (tx_data/tx_valid/tx_taken). SCL/SDA are open-drain: *_oe = 1 pulls low.
// Optional clock stretching on an empty transmit slot: I2C_SLAVE_CLK_STRETCH_EN.
// SYNC_STAGES must be at least 2.
module i2c_slave_controller #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       core_clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic [6:0] own_address,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_taken,
  output logic       busy,
  output logic       read_mode
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_prev_q, sda_prev_q;
  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
  logic       rx_valid_q, rx_valid_d, tx_taken_q, tx_taken_d;
  logic       read_mode_q, read_mode_d, mack_q, mack_d;
  logic       tx_load;

  // Bus synchronizers plus one delayed copy for edge detection; idle bus is high.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SCL must be high in both samples so SDA/SCL skew is not taken as START/STOP.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // Protocol FSM registers.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_taken_q  <= 1'b0;
      read_mode_q <= 1'b0;
      mack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      sda_oe_q    <= sda_oe_d;
      scl_oe_q    <= scl_oe_d;
      rx_valid_q  <= rx_valid_d;
      tx_taken_q  <= tx_taken_d;
      read_mode_q <= read_mode_d;
      mack_q      <= mack_d;
    end
  end

  // Next-state logic. In the ACK states sda_oe_q doubles as the phase marker:
  // the first SCL fall starts driving the ACK, the second ends the ACK bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    sda_oe_d    = sda_oe_q;
    scl_oe_d    = scl_oe_q;
    rx_valid_d  = 1'b0;
    tx_taken_d  = 1'b0;
    read_mode_d = read_mode_q;
    mack_d      = mack_q;
    tx_load     = 1'b0;
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      mack_d   = 1'b0;
    end else if (start_det) begin
      // A real START implies SDA was released, so clearing sda_oe is a no-op on the bus.
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      mack_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (shift_d[7:1] == own_address) begin
              state_d     = ADDR_ACK;
              read_mode_d = sda_s;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!sda_oe_q) sda_oe_d = 1'b1;
          else if (read_mode_q) begin
            state_d = TX_DATA;
            tx_load = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = RX_DATA;
          end
        end
        RX_DATA: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_d  = shift_d;
            rx_valid_d = 1'b1;
            state_d    = rx_ready ? RX_ACK : IGNORE;
          end
        end
        RX_ACK: if (scl_fall) begin
          if (!sda_oe_q) sda_oe_d = 1'b1;
          else begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = RX_DATA;
          end
        end
        TX_DATA: begin
          // SCL held low by us means a load is still waiting on tx_valid.
          if (scl_oe_q) tx_load = 1'b1;
          else if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              mack_d   = 1'b0;
              state_d  = TX_ACK;
            end else begin
              cnt_d    = cnt_q + 3'd1;
              sda_oe_d = ~shift_q[6];
              shift_d  = {shift_q[6:0], 1'b1};
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = IGNORE;
            else       mack_d  = 1'b1;
          end else if (scl_fall && mack_q) begin
            mack_d  = 1'b0;
            state_d = TX_DATA;
            tx_load = 1'b1;
          end
        end
        default: ;
      endcase
      // Transmit byte load, always on an SCL-low phase; drives bit 7 immediately.
      if (tx_load) begin
        cnt_d = '0;
        if (tx_valid) begin
          shift_d    = tx_data;
          tx_taken_d = 1'b1;
          sda_oe_d   = ~tx_data[7];
          scl_oe_d   = 1'b0;
        end else begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
          scl_oe_d = 1'b1;
          sda_oe_d = 1'b0;
`else
          shift_d  = 8'hFF;
          sda_oe_d = 1'b0;
`endif
        end
      end
    end
  end

  assign sda_oe    = sda_oe_q;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  assign scl_oe    = scl_oe_q;
`else
  assign scl_oe    = 1'b0;
`endif
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_taken  = tx_taken_q;
  assign busy      = (state_q != IDLE);
  assign read_mode = read_mode_q;

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Bench for i2c_slave_controller: a bit-banged I2C master with an open-drain
// bus, a transaction-level reference model that fills rx/tx scoreboards, and
// a monitor that pops them on every rx_valid / tx_taken pulse.
module tb_i2c_slave_controller;
  localparam int Q = 6; // core clocks per quarter SCL period

  logic       core_clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_in, sda_in;
  logic [6:0] own_address = 7'h50;
  logic       sda_oe, scl_oe, rx_valid, tx_taken, busy, read_mode;
  logic       rx_ready = 1'b1, tx_valid = 1'b0;
  logic [7:0] rx_data, tx_data = 8'h00;

  assign scl_in = scl_m & ~scl_oe;
  assign sda_in = sda_m & ~sda_oe;

  int errors = 0, checks = 0;
  logic [7:0] exp_rx[$], exp_tx[$];
  logic [7:0] pl[5];
  bit oe_seen, scl_oe_seen, watch_busy, busy_drop, rxv_prev, txt_prev;

  always #5 core_clk = ~core_clk;

  i2c_slave_controller #(.SYNC_STAGES(2)) dut (
    .core_clk(core_clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .own_address(own_address), .sda_oe(sda_oe), .scl_oe(scl_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_taken(tx_taken),
    .busy(busy), .read_mode(read_mode)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic chk_true(input string name, input bit c);
    chk(name, {31'd0, c}, 32'd1);
  endtask

  // Monitor: pops the scoreboards on handshake pulses.
  initial forever begin
    @(negedge core_clk);
    if (rx_valid) begin
      chk_true("rx_valid_one_cycle", !rxv_prev);
      chk_true("rx_valid_expected", exp_rx.size() != 0);
      if (exp_rx.size() != 0) chk("rx_data", rx_data, exp_rx.pop_front());
    end
    if (tx_taken) begin
      chk_true("tx_taken_one_cycle", !txt_prev);
      chk_true("tx_taken_expected", exp_tx.size() != 0);
      if (exp_tx.size() != 0) chk("tx_taken_byte", tx_data, exp_tx.pop_front());
    end
    if (rx_valid || tx_taken) chk_true("pulse_exclusive", !(rx_valid && tx_taken));
    rxv_prev = rx_valid;
    txt_prev = tx_taken;
    if (sda_oe) oe_seen = 1'b1;
    if (scl_oe) scl_oe_seen = 1'b1;
    if (watch_busy && !busy) busy_drop = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic q();
    repeat (Q) @(negedge core_clk);
  endtask

  // Release SCL and wait (bounded) for the slave to let it rise.
  task automatic scl_up();
    int t;
    t = 0;
    scl_m = 1'b1;
    #0;
    while (scl_in !== 1'b1 && t < 4000) begin
      @(negedge core_clk);
      t++;
    end
    if (scl_in !== 1'b1) chk_true("scl_release_timeout", scl_in === 1'b1);
  endtask

  task automatic start_c();
    sda_m = 1'b1; q(); scl_up(); q(); sda_m = 1'b0; q(); scl_m = 1'b0; q();
  endtask

  task automatic stop_c();
    sda_m = 1'b0; q(); scl_up(); q(); sda_m = 1'b1; q();
  endtask

  task automatic wbit(input logic b);
    sda_m = b; q(); scl_up(); q(); q(); scl_m = 1'b0; q();
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; q(); scl_up(); q(); b = sda_in; q(); scl_m = 1'b0; q();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      rbit(bt);
      d[i] = bt;
    end
  endtask

  // One START..STOP transaction; expectations come from the transaction rules:
  // matched address ACKs, writes ACK while rx_ready, every byte clocked into a
  // live write is reported, reads return tx_data (0xFF when none), master NACK ends.
  task automatic run_txn(input logic [7:0] ab, input int n, input bit rdy, input bit tv);
    bit match, rd, live;
    logic ackb;
    logic [7:0] d;
    match = (ab[7:1] == own_address);
    rd    = ab[0];
    live  = match;
    rx_ready = rdy;
    tx_valid = tv;
    tx_data  = pl[0];
    if (live && rd && tv) exp_tx.push_back(pl[0]);
    start_c();
    oe_seen = 1'b0;
    chk("busy_after_start", busy, 1);
    wbyte(ab, ackb);
    chk("addr_ack", ackb, !match);
    if (match) chk("read_mode", read_mode, rd);
    for (int i = 0; i < n; i++) begin
      if (!rd) begin
        if (live) exp_rx.push_back(pl[i]);
        wbyte(pl[i], ackb);
        chk("data_ack", ackb, !(live && rdy));
        if (live && !rdy) begin
          live    = 1'b0;
          oe_seen = 1'b0;
        end
      end else begin
        rbyte(d);
        chk("read_data", d, (live && tv) ? pl[i] : 8'hFF);
        tx_data = pl[i+1];
        if (live && tv && i != n-1) exp_tx.push_back(pl[i+1]);
        wbit(i == n-1);
      end
    end
    stop_c();
    q();
    chk("busy_after_stop", busy, 0);
    chk("rx_scoreboard_drained", exp_rx.size(), 0);
    chk("tx_scoreboard_drained", exp_tx.size(), 0);
    if (!live) chk("quiet_sda_oe", oe_seen, 0);
  endtask

  initial begin : main
    logic ackb;
    logic [7:0] d, ab;
    int n;
    bit rdy, tv;
    #1 rst = 1'b1;
    repeat (3) @(negedge core_clk);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_taken", tx_taken, 0);
    chk("rst_busy", busy, 0);
    chk("rst_read_mode", read_mode, 0);
    rst = 1'b0;
    q();

    // Plain write, then address mismatch, read, backpressure.
    pl = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(8'hA0, 1, 1'b1, 1'b1);
    chk("write_rx_data_held", rx_data, 8'h3C);
    pl = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(8'hA2, 1, 1'b1, 1'b1);
    pl = '{8'h96, 8'h96, 8'h96, 8'h00, 8'h00};
    run_txn(8'hA1, 2, 1'b1, 1'b1);
    pl = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
    run_txn(8'hA0, 2, 1'b0, 1'b1);
`ifndef I2C_SLAVE_CLK_STRETCH_EN
    pl = '{8'h77, 8'h88, 8'h00, 8'h00, 8'h00};
    run_txn(8'hA1, 2, 1'b1, 1'b0);
`endif

    // Repeated START mid-byte: write then re-address for read, busy never drops.
    rx_ready = 1'b1; tx_valid = 1'b1; tx_data = 8'h96;
    start_c();
    busy_drop = 1'b0; watch_busy = 1'b1;
    wbyte(8'hA0, ackb); chk("rs_addr_ack", ackb, 0);
    exp_rx.push_back(8'h01);
    wbyte(8'h01, ackb); chk("rs_data_ack", ackb, 0);
    exp_tx.push_back(8'h96);
    start_c();
    chk("rs_busy", busy, 1);
    wbyte(8'hA1, ackb); chk("rs_readdr_ack", ackb, 0);
    chk("rs_read_mode", read_mode, 1);
    rbyte(d); chk("rs_read_data", d, 8'h96);
    wbit(1'b1);
    watch_busy = 1'b0;
    chk("rs_busy_held", busy_drop, 0);
    stop_c(); q();
    chk("rs_busy_after_stop", busy, 0);
    chk("rs_drained", exp_rx.size() + exp_tx.size(), 0);

    // Randomized transactions.
    for (int k = 0; k < 20; k++) begin
      ab  = {($urandom_range(0, 3) != 0) ? 7'h50 : 7'($urandom_range(0, 127)),
             1'($urandom_range(0, 1))};
      n   = $urandom_range(1, 4);
      rdy = ($urandom_range(0, 4) != 0);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      tv  = 1'b1;
`else
      tv  = ($urandom_range(0, 3) != 0);
`endif
      for (int j = 0; j < 5; j++) pl[j] = 8'($urandom);
      run_txn(ab, n, rdy, tv);
    end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    // Stretch: empty tx slot at the read address ACK holds SCL low.
    tx_valid = 1'b0; tx_data = 8'h5A;
    start_c();
    wbyte(8'hA1, ackb); chk("st_addr_ack", ackb, 0);
    repeat (40) @(negedge core_clk);
    chk("st_scl_held", scl_oe, 1);
    exp_tx.push_back(8'h5A);
    tx_valid = 1'b1;
    repeat (4) @(negedge core_clk);
    chk("st_scl_released", scl_oe, 0);
    chk("st_bit7_driven", sda_oe, 1);
    rbyte(d); chk("st_read_data", d, 8'h5A);
    wbit(1'b1);
    stop_c(); q();
    chk("st_drained", exp_tx.size(), 0);
`endif

    // Reset in the middle of an address byte: the rest of the transfer is ignored.
    rx_ready = 1'b1;
    start_c();
    wbit(1'b1); wbit(1'b0); wbit(1'b1);
    rst = 1'b1;
    repeat (3) @(negedge core_clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sda_oe", sda_oe, 0);
    chk("mid_rst_rx_data", rx_data, 0);
    chk("mid_rst_read_mode", read_mode, 0);
    rst = 1'b0;
    oe_seen = 1'b0;
    wbit(1'b0); wbit(1'b0); wbit(1'b0); wbit(1'b0); wbit(1'b0);
    rbit(ackb); chk("post_rst_addr_nack", ackb, 1);
    chk("post_rst_busy", busy, 0);
    wbyte(8'h3C, ackb); chk("post_rst_data_nack", ackb, 1);
    stop_c(); q();
    chk("post_rst_quiet", oe_seen, 0);
    chk("post_rst_no_rx", exp_rx.size(), 0);

`ifndef I2C_SLAVE_CLK_STRETCH_EN
    chk("scl_oe_never", scl_oe_seen, 0);
`endif

    repeat (10) @(negedge core_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_slave_controller.md
I2C_SLAVE_CONTROLLER -- requirements
Module: i2c_slave_controller

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on scl_in/sda_in (minimum 2).
REQ-002 SHALL have port core_clk  input  1  system clock; all logic is on its rising edge; one clock domain only.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port scl_in  input  1  sampled SCL bus level.
REQ-005 SHALL have port sda_in  input  1  sampled SDA bus level.
REQ-006 SHALL have port own_address  input  7  slave address to match, held stable while busy.
REQ-007 SHALL have port sda_oe  output  1  1 = pull SDA low, 0 = release.
REQ-008 SHALL have port scl_oe  output  1  1 = pull SCL low (clock stretch), 0 = release.
REQ-009 SHALL have port rx_data  output  8  last received data byte.
REQ-010 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-011 SHALL have port rx_ready  input  1  sink can accept a byte; sampled at the 8th data bit.
REQ-012 SHALL have port tx_data  input  8  byte to return on a master read.
REQ-013 SHALL have port tx_valid  input  1  tx_data is available.
REQ-014 SHALL have port tx_taken  output  1  one-cycle pulse when tx_data is loaded into the shifter.
REQ-015 SHALL have port busy  output  1  high from START to STOP.
REQ-016 SHALL have port read_mode  output  1  R/W bit of the last matched address (1 = read).

Function
REQ-017 SHALL synchronize scl_in/sda_in through SYNC_STAGES flops, then detect edges against a one-cycle-delayed copy.
REQ-018 SHALL detect START as synchronized SDA falling while SCL high, and STOP as SDA rising while SCL high.
REQ-019 SHALL use states IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, IGNORE.
REQ-020 SHALL move to ADDR and clear the bit counter on START from any state, including repeated START mid-byte.
REQ-021 SHALL move to IDLE and release sda_oe/scl_oe on STOP from any state.
REQ-022 SHALL sample SDA on each SCL rising edge and shift it in MSB first; a 3-bit counter counts bits 0-7.
REQ-023 SHALL, after the 8th address bit, compare bits[7:1] to own_address: match goes to ADDR_ACK and latches read_mode; mismatch goes to IGNORE, which holds until START or STOP.
REQ-024 SHALL assert sda_oe at the SCL falling edge that starts the ACK bit and release it at the following SCL falling edge.
REQ-025 SHALL change sda_oe only on synchronized SCL falling edges, never while SCL is high, except for the release on STOP.
REQ-026 SHALL in RX_DATA, on the 8th rising edge, update rx_data and pulse rx_valid the next cycle; ACK if rx_ready=1, else NACK and go to IGNORE.
REQ-027 SHALL on entering a read, and on each master ACK, load tx_data and pulse tx_taken if tx_valid=1, then drive sda_oe = ~bit MSB first on each SCL falling edge.
REQ-028 SHALL release SDA after the 8th TX bit, then sample the master ACK on the 9th rising edge: 0 loads the next byte, 1 goes to IGNORE.
REQ-029 SHALL assert rx_valid and tx_taken for exactly one core_clk, and never both in the same cycle.

Reset
REQ-030 SHALL, while rst=1, force state IDLE, sda_oe=0, scl_oe=0, rx_data=0x00, rx_valid=0, tx_taken=0, busy=0, read_mode=0, all synchronizers to 1.
REQ-031 SHALL, after reset deassertion mid-transfer, ignore bus activity until the next START.

Configuration
REQ-032 SHALL compile clock stretching only when macro I2C_SLAVE_CLK_STRETCH_EN is defined: a TX load with tx_valid=0 holds scl_oe=1 from the SCL falling edge until tx_valid=1, then loads, drives bit 7 and releases SCL.
REQ-033 SHALL, without I2C_SLAVE_CLK_STRETCH_EN, tie scl_oe to 0 and transmit 0xFF without pulsing tx_taken when tx_valid=0.

Verification
REQ-034 SHALL cover write: own_address=0x50; master sends START, 0xA0, 0x3C, STOP -> ACK on both bytes, rx_data=0x3C, one rx_valid pulse, busy low after STOP.
REQ-035 SHALL cover address mismatch: master sends 0xA2 -> sda_oe stays 0 for the whole transfer, no rx_valid pulse.
REQ-036 SHALL cover read: tx_data=0x96, tx_valid=1; master sends 0xA1, reads 2 bytes, ACK then NACK -> SDA bits 10010110 twice, two tx_taken pulses, IGNORE then IDLE on STOP.
REQ-037 SHALL cover backpressure: rx_ready=0 at the 8th bit of a write -> NACK, IGNORE state, no sda_oe until the next START.
REQ-038 SHALL cover repeated START: 0xA0, 0x01, repeated START, 0xA1 -> ADDR re-entered, read_mode=1, busy held high throughout.
REQ-039 SHALL cover stretching with the macro defined: tx_valid=0 at the read address ACK -> scl_oe=1 until tx_valid rises, then SCL released and bit 7 driven.
